nios2_system_datain_edge_pio: RTL and testbench



---
 rtl/nios2_system_datain_edge_pio_if.sv | 19 +
 rtl/nios2_system_datain_edge_pio.sv | 107 ++++++++++
 tb/tb_nios2_system_datain_edge_pio.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/nios2_system_datain_edge_pio_if.sv
// Avalon-MM slave bus for the data-in edge PIO. A transfer is one cycle:
// chipselect && !write_n writes at the next edge; readdata is valid one cycle after address.
interface nios2_system_datain_edge_pio_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/nios2_system_datain_edge_pio.sv
// Input PIO: synchronizes in_port, captures per-bit edges into a sticky register, maskable irq.
// Optional macro DATAIN_EDGE_PIO_BITCLEAR_EN: EDGECAP writes clear only the bits set in writedata.
module nios2_system_datain_edge_pio #(
  parameter int              WIDTH       = 8,
  parameter int              SYNC_STAGES = 2,
  parameter int              EDGE_TYPE   = 0,
  parameter logic [WIDTH-1:0] RESET_MASK = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  nios2_system_datain_edge_pio_if.slave avs,
  input  logic [WIDTH-1:0]              in_port,
  output logic                          irq
);

  localparam logic [2:0] PRIME_CYCLES = 3'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_r;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev_q;
  logic [2:0]       prime_cnt;
  logic             primed;
  logic [WIDTH-1:0] raw_edge;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] edgecap;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] clr;
  logic [31:0]      rd_mux;
  logic             wr_en;
  logic             wr_mask;
  logic             wr_edgecap;
  logic             unused_writedata;

  assign sync_q = sync_r[SYNC_STAGES-1];
  assign primed = (prime_cnt == PRIME_CYCLES);

  assign wr_en      = avs.chipselect && !avs.write_n;
  assign wr_mask    = wr_en && (avs.address == 2'd2);
  assign wr_edgecap = wr_en && (avs.address == 2'd3);

  // Upper writedata bits are architecturally ignored.
  assign unused_writedata = ^avs.writedata;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_r    <= '0;
      prev_q    <= '0;
      prime_cnt <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], in_port};
      prev_q <= sync_q;
      if (!primed) prime_cnt <= prime_cnt + 3'd1;
    end
  end

  always_comb begin
    raw_edge = '0;
    case (EDGE_TYPE)
      0:       raw_edge = sync_q & ~prev_q;
      1:       raw_edge = ~sync_q & prev_q;
      default: raw_edge = sync_q ^ prev_q;
    endcase
  end

  // Suppress edges while the synchronizer and prev stage fill after reset.
  assign edge_det = primed ? raw_edge : '0;

  always_comb begin
    clr = '0;
    if (wr_edgecap) begin
`ifdef DATAIN_EDGE_PIO_BITCLEAR_EN
      clr = avs.writedata[WIDTH-1:0];
`else
      clr = '1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      edgecap <= '0;
      irqmask <= RESET_MASK;
    end else begin
      // A new edge on a bit being cleared wins.
      edgecap <= (edgecap & ~clr) | edge_det;
      if (wr_mask) irqmask <= avs.writedata[WIDTH-1:0];
    end
  end

  assign irq = |(edgecap & irqmask);

  always_comb begin
    rd_mux = '0;
    case (avs.address)
      2'd0:    rd_mux[WIDTH-1:0] = sync_q;
      2'd2:    rd_mux[WIDTH-1:0] = irqmask;
      2'd3:    rd_mux[WIDTH-1:0] = edgecap;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) avs.readdata <= '0;
    else       avs.readdata <= rd_mux;
  end

endmodule

// File: tb/tb_nios2_system_datain_edge_pio.sv
// Directed bench for the data-in edge PIO; expectations follow DATAIN_EDGE_PIO_BITCLEAR_EN.
module tb_nios2_system_datain_edge_pio;
  logic       clk;
  logic       reset;
  logic [7:0] in_port;
  logic       irq;
  int         n_checks;
  int         n_fail;
  logic [7:0] exp_q[$];

  nios2_system_datain_edge_pio_if bus();

  nios2_system_datain_edge_pio dut (
    .clk     (clk),
    .reset   (reset),
    .avs     (bus),
    .in_port (in_port),
    .irq     (irq)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks: inputs change 1 time unit after a rising edge, outputs sampled there too
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    tick(1);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    tick(1);
    d = bus.readdata;
    bus.chipselect = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] r;
    reset = 1'b1;
    in_port = 8'hFF;
    bus.address = 2'd0;
    tick(10);
    n_checks++;
    if (bus.readdata !== 32'h0) begin n_fail++; $display("FAIL reset_readdata got %h want %h", bus.readdata, 32'h0); end
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b want 0", irq); end
    reset = 1'b0;
    tick(2);
    n_checks++;
    if (bus.readdata !== 32'h0) begin n_fail++; $display("FAIL data_latency_early got %h want %h", bus.readdata, 32'h0); end
    tick(1);
    n_checks++;
    if (bus.readdata !== 32'hFF) begin n_fail++; $display("FAIL data_after_3 got %h want %h", bus.readdata, 32'hFF); end
    tick(5);
    bus_read(2'd3, r);
    n_checks++;
    if (r !== 32'h0) begin n_fail++; $display("FAIL reset_edgecap got %h want %h", r, 32'h0); end
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq_after got %b want 0", irq); end
    bus_read(2'd2, r);
    n_checks++;
    if (r !== 32'h0) begin n_fail++; $display("FAIL reset_irqmask got %h want %h", r, 32'h0); end
    bus_write(2'd1, 32'hFFFF_FFFF);
    bus_read(2'd1, r);
    n_checks++;
    if (r !== 32'h0) begin n_fail++; $display("FAIL reserved_read got %h want %h", r, 32'h0); end
  endtask

  task automatic test_data_path;
    logic [31:0] r;
    logic [7:0]  vals [3];
    logic [7:0]  e;
    vals[0] = 8'h5A; vals[1] = 8'hA5; vals[2] = 8'h3C;
    for (int i = 0; i < 3; i++) begin
      in_port = vals[i];
      tick(4);
      exp_q.push_back(vals[i]);
      bus_read(2'd0, r);
      e = exp_q.pop_front();
      n_checks++;
      if (r !== {24'h0, e}) begin n_fail++; $display("FAIL data_read[%0d] got %h want %h", i, r, {24'h0, e}); end
    end
  endtask

  task automatic test_rising_irq;
    logic [31:0] r;
    in_port = 8'h00;
    tick(5);
    bus_write(2'd3, 32'hFF);
    bus_read(2'd3, r);
    n_checks++;
    if (r !== 32'h0) begin n_fail++; $display("FAIL clear_all got %h want %h", r, 32'h0); end
    bus_write(2'd2, 32'h01);
    in_port = 8'h01;
    tick(2);
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_early got %b want 0", irq); end
    tick(1);
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_rise got %b want 1", irq); end
    bus_read(2'd3, r);
    n_checks++;
    if (r !== 32'h01) begin n_fail++; $display("FAIL edgecap_bit0 got %h want %h", r, 32'h01); end
    bus_write(2'd3, 32'hFF);
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear got %b want 0", irq); end
  endtask

  task automatic test_mask;
    logic [31:0] r;
    bus_write(2'd2, 32'h00);
    in_port = 8'h81;
    tick(4);
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_masked got %b want 0", irq); end
    bus_read(2'd3, r);
    n_checks++;
    if (r !== 32'h80) begin n_fail++; $display("FAIL edgecap_bit7 got %h want %h", r, 32'h80); end
    bus_write(2'd2, 32'hFFFF_FF80);
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_unmask got %b want 1", irq); end
    bus_read(2'd2, r);
    n_checks++;
    if (r !== 32'h80) begin n_fail++; $display("FAIL irqmask_read got %h want %h", r, 32'h80); end
    bus_write(2'd3, 32'hFF);
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear2 got %b want 0", irq); end
  endtask

  task automatic test_clear_collision;
    logic [31:0] r;
    in_port = 8'h80;
    tick(4);
    in_port = 8'h81;
    tick(5);
    bus_read(2'd3, r);
    n_checks++;
    if (r !== 32'h01) begin n_fail++; $display("FAIL collision_setup got %h want %h", r, 32'h01); end
    // bit 2 rises; its edge is at the detector when the clear write lands
    in_port = 8'h85;
    tick(2);
    bus_write(2'd3, 32'hFF);
    bus_read(2'd3, r);
    n_checks++;
    if (r !== 32'h04) begin n_fail++; $display("FAIL collision_edge_wins got %h want %h", r, 32'h04); end
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL collision_irq got %b want 0", irq); end
  endtask

  task automatic test_bitclear;
    logic [31:0] r;
    logic [31:0] want;
    bus_write(2'd3, 32'hFF);
    in_port = 8'h00;
    tick(5);
    in_port = 8'h0F;
    tick(4);
    bus_read(2'd3, r);
    n_checks++;
    if (r !== 32'h0F) begin n_fail++; $display("FAIL bitclear_setup got %h want %h", r, 32'h0F); end
    bus_write(2'd3, 32'h05);
`ifdef DATAIN_EDGE_PIO_BITCLEAR_EN
    want = 32'h0A;
`else
    want = 32'h00;
`endif
    bus_read(2'd3, r);
    n_checks++;
    if (r !== want) begin n_fail++; $display("FAIL bitclear_result got %h want %h", r, want); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] r;
    bus_write(2'd3, 32'hFF);
    in_port = 8'h00;
    tick(5);
    bus_write(2'd3, 32'hFF);
    in_port = 8'h3C;
    tick(4);
    bus_write(2'd2, 32'h3C);
    bus_read(2'd3, r);
    n_checks++;
    if (r !== 32'h3C) begin n_fail++; $display("FAIL midreset_setup got %h want %h", r, 32'h3C); end
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL midreset_irq_pre got %b want 1", irq); end
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL midreset_irq got %b want 0", irq); end
    n_checks++;
    if (bus.readdata !== 32'h0) begin n_fail++; $display("FAIL midreset_readdata got %h want %h", bus.readdata, 32'h0); end
    bus_read(2'd2, r);
    n_checks++;
    if (r !== 32'h0) begin n_fail++; $display("FAIL midreset_irqmask got %h want %h", r, 32'h0); end
    tick(6);
    bus_read(2'd3, r);
    n_checks++;
    if (r !== 32'h0) begin n_fail++; $display("FAIL midreset_edgecap got %h want %h", r, 32'h0); end
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    reset          = 1'b1;
    in_port        = 8'h00;
    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    test_reset();
    test_data_path();
    test_rising_irq();
    test_mask();
    test_clear_collision();
    test_bitclear();
    test_reset_mid();
    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
